matrix_stream_unpacker: RTL

- Reads a flat row-major L x N matrix of 32-bit IEEE-754 words, e.g. the `result` bus of the sequential matrix multiplier.
- Streams the matrix out one element per valid/ready handshake.
- Feeds downstream serial consumers: activation unit, float UART/debug dump, next-layer loaders.
- Captures a snapshot on `start`, so the source bus may change freely during streaming.

---
 rtl/matrix_stream_unpacker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/matrix_stream_unpacker.sv
// Snapshots a flat row-major L x N matrix of 32-bit words on start and streams it out one element per valid/ready handshake.
// Optional build macro MATRIX_STREAM_TRANSPOSE_EN: column-major walk (transpose), indices still report source (r,c).
module matrix_stream_unpacker #(
  parameter int L = 1,
  parameter int N = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [32*L*N-1:0]               matrix,
  output logic                            busy,
  output logic [31:0]                     m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [((L > 1) ? $clog2(L) : 1)-1:0] m_row,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_col,
  output logic                            m_last,
  output logic                            done
);

  localparam int RW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int E  = L * N;
  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam logic [RW-1:0] R_MAX = RW'(L - 1);
  localparam logic [CW-1:0] C_MAX = CW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_reg, state_next;
  logic [32*E-1:0]   snap_reg, snap_next;
  logic [RW-1:0]     r_reg, r_next, r_adv;
  logic [CW-1:0]     c_reg, c_next, c_adv;
  logic [31:0]       data_reg, data_next;
  logic              last_reg, last_next;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;
  logic [IW-1:0]     idx_adv;

  // Split the snapshot into addressable words.
  logic [31:0] elem [E];
  for (genvar gi = 0; gi < E; gi++) begin : g_elem
    assign elem[gi] = snap_reg[32*gi +: 32];
  end

  // Successor of the current (r,c); only consulted when the current element is not the last.
  always_comb begin
    r_adv = r_reg;
    c_adv = c_reg;
`ifdef MATRIX_STREAM_TRANSPOSE_EN
    if (r_reg == R_MAX) begin
      r_adv = '0;
      c_adv = c_reg + 1'b1;
    end else begin
      r_adv = r_reg + 1'b1;
    end
`else
    if (c_reg == C_MAX) begin
      c_adv = '0;
      r_adv = r_reg + 1'b1;
    end else begin
      c_adv = c_reg + 1'b1;
    end
`endif
    idx_adv = IW'(r_adv) * IW'(N) + IW'(c_adv);
  end

  always_comb begin
    state_next = state_reg;
    snap_next  = snap_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          snap_next  = matrix;
          r_next     = '0;
          c_next     = '0;
          data_next  = matrix[31:0];
          last_next  = (E == 1);
          valid_next = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (valid_reg && m_ready) begin
          if (last_reg) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            r_next    = r_adv;
            c_next    = c_adv;
            data_next = elem[idx_adv];
            last_next = (r_adv == R_MAX) && (c_adv == C_MAX);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      snap_reg  <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      snap_reg  <= snap_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  assign busy    = (state_reg == STREAM);
  assign m_data  = data_reg;
  assign m_valid = valid_reg;
  assign m_row   = r_reg;
  assign m_col   = c_reg;
  assign m_last  = last_reg;
  assign done    = done_reg;

endmodule
